// File: rtl/bridge_pkg.sv
// Shared types and constants for the UART-to-register-bus bridge.
package bridge_pkg;

  typedef enum logic [3:0] {
    IDLE, GET_HI, GET_LO, BUS_WR, BUS_RD, RD_WAIT, TX0, TXW0, TX1, TXW1
  } state_t;

  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam int         CMD_WR_BIT   = 7;
  localparam int         CMD_SYNC_MSB = 6;
  localparam int         CMD_SYNC_LSB = 4;
  localparam int         CMD_ADDR_MSB = 3;
  localparam int         CMD_ADDR_LSB = 0;
  localparam logic [7:0] DEFAULT_ACK  = 8'h06;

  function automatic logic cmd_sync_ok(input logic [7:0] cmd);
    return (cmd[CMD_SYNC_MSB:CMD_SYNC_LSB] == SYNC_PATTERN);
  endfunction

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte watchdog: loads TIMEOUT_CYC on clear, counts down while enabled, flags expiry at zero.
// Single-cycle registered count; expired is combinational from the count.
module bridge_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int             W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0]   LOAD = W'(TIMEOUT_CYC);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/uart_bus_bridge.sv
// Decodes UART command frames into single-cycle register-bus reads/writes and returns ack/read bytes.
// Bus strobe one cycle after the final frame byte; responses wait for tx_busy low, extra rx bytes are dropped.
module uart_bus_bridge
  import bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         RD_LAT      = 1,
  parameter logic [7:0] ACK_BYTE    = DEFAULT_ACK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_cs,
  output logic [3:0]  bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic        frame_err
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t      r_state;
  logic        r_bus_cs;
  logic        r_bus_rd;
  logic        r_bus_wr;
  logic [3:0]  r_bus_addr;
  logic [15:0] r_bus_wdata;
  logic [15:0] r_rdata;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_frame_err;
  logic        r_is_rd;
  logic [1:0]  r_lat_cnt;

  logic w_rx_ok_state;
  logic w_clear;
  logic w_en;
  logic w_expired;

  assign w_rx_ok_state = (r_state == IDLE) || (r_state == GET_HI) || (r_state == GET_LO);
  assign w_clear       = rx_valid && w_rx_ok_state;
  assign w_en          = (r_state == GET_HI) || (r_state == GET_LO);

  bridge_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_en      (w_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bus_cs    <= 1'b0;
      r_bus_rd    <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_addr  <= 4'h0;
      r_bus_wdata <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_frame_err <= 1'b0;
      r_is_rd     <= 1'b0;
      r_lat_cnt   <= 2'd0;
    end else begin
      r_frame_err <= rx_valid && !w_rx_ok_state;
      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            if (cmd_sync_ok(rx_data)) begin
              r_bus_addr <= rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
              r_is_rd    <= !rx_data[CMD_WR_BIT];
              if (rx_data[CMD_WR_BIT]) begin
                r_state <= GET_HI;
              end else begin
                r_state  <= BUS_RD;
                r_bus_cs <= 1'b1;
                r_bus_rd <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        GET_HI: begin
          if (rx_valid) begin
            r_bus_wdata[15:8] <= rx_data;
            r_state           <= GET_LO;
          end else if (w_expired) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
          end
        end
        GET_LO: begin
          if (rx_valid) begin
            r_bus_wdata[7:0] <= rx_data;
            r_state          <= BUS_WR;
            r_bus_cs         <= 1'b1;
            r_bus_wr         <= 1'b1;
          end else if (w_expired) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
          end
        end
        BUS_WR: begin
          r_bus_cs <= 1'b0;
          r_bus_wr <= 1'b0;
          r_state  <= TX0;
        end
        BUS_RD: begin
          r_bus_cs  <= 1'b0;
          r_bus_rd  <= 1'b0;
          r_lat_cnt <= 2'd0;
          r_state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (r_lat_cnt == LAT_LAST) begin
            r_rdata <= bus_rdata;
            r_state <= TX0;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        TX0: begin
          if (!tx_busy) begin
            r_tx_data  <= r_is_rd ? r_rdata[15:8] : ACK_BYTE;
            r_tx_start <= 1'b1;
            r_state    <= TXW0;
          end
        end
        TX1: begin
          if (!tx_busy) begin
            r_tx_data  <= r_rdata[7:0];
            r_tx_start <= 1'b1;
            r_state    <= TXW1;
          end
        end
        // The first wait cycle is the tx_start cycle itself; busy only rises after it.
        TXW0, TXW1: begin
          if (r_tx_start) begin
            r_tx_start <= 1'b0;
          end else if (!tx_busy) begin
            r_state <= ((r_state == TXW0) && r_is_rd) ? TX1 : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_cs    = r_bus_cs;
  assign bus_rd    = r_bus_rd;
  assign bus_wr    = r_bus_wr;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: frame-level reference model with queued bus/tx expectations,
// peripheral and transmitter stand-ins, directed corner cases and randomised frames.
module tb_uart_bus_bridge;

  localparam int         TO  = 100;
  localparam int         RL  = 1;
  localparam logic [7:0] ACK = 8'h06;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy   = 1'b0;
  logic        bus_cs;
  logic [3:0]  bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata = 16'h0000;
  logic        frame_err;

  uart_bus_bridge #(
    .TIMEOUT_CYC (TO),
    .RD_LAT      (RL),
    .ACK_BYTE    (ACK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .bus_cs    (bus_cs),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data;
  } bop_t;

  bop_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [15:0] ref_mem[16];
  logic [3:0]  mdl_addr = 4'h0;
  logic [15:0] mdl_wd   = 16'h0000;
  int          exp_err  = 0;
  int          seen_err = 0;
  int          checks   = 0;
  int          errors   = 0;
  logic        last_wr  = 1'b0;
  logic [3:0]  last_addr = 4'h0;
  logic [15:0] last_wd  = 16'h0000;

  function automatic logic [15:0] init_val(input int i);
    return (i == 5) ? 16'hBEEF : 16'((i * 16'h1357) ^ 16'hA5A5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Peripheral stand-in: register file, read data valid only RL cycles after the strobe.
  initial begin : periph_model
    logic [15:0] periph[16];
    logic        s_rd;
    logic        s_wr;
    logic [3:0]  s_a;
    logic [15:0] s_wd;
    logic        pv[RL];
    logic [15:0] pd[RL];
    for (int i = 0; i < 16; i++) periph[i] = init_val(i);
    for (int i = 0; i < RL; i++) begin
      pv[i] = 1'b0;
      pd[i] = 16'h0000;
    end
    forever begin
      @(negedge clk);
      s_rd = bus_rd;
      s_wr = bus_wr;
      s_a  = bus_addr;
      s_wd = bus_wdata;
      @(posedge clk);
      #1;
      if (s_wr) periph[s_a] = s_wd;
      for (int i = RL - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = s_rd;
      pd[0] = periph[s_a];
      bus_rdata = pv[RL-1] ? pd[RL-1] : 16'($urandom);
    end
  end

  // Transmitter stand-in: busy from the cycle after tx_start for a random length.
  initial begin : tx_model
    int n;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n = $urandom_range(3, 10);
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (n) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin : compare
    logic       prev_strobe;
    logic       prev_err;
    bop_t       e;
    logic [7:0] t;
    prev_strobe = 1'b0;
    prev_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_strobe = 1'b0;
        prev_err    = 1'b0;
      end else begin
        chk("rd_wr_exclusive", 32'(bus_rd & bus_wr), 32'd0);
        chk("cs_matches_strobe", 32'(bus_cs), 32'(bus_rd | bus_wr));
        if (bus_rd | bus_wr) begin
          chk("strobe_one_cycle", 32'(prev_strobe), 32'd0);
          if (exp_bus.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bus_strobe: got rd=%0b wr=%0b addr=%0h, expected no strobe (t=%0t)",
                     bus_rd, bus_wr, bus_addr, $time);
          end else begin
            e = exp_bus.pop_front();
            chk("bus_kind_wr", 32'(bus_wr), 32'(e.wr));
            chk("bus_addr", 32'(bus_addr), 32'(e.addr));
            if (e.wr) chk("bus_wdata", 32'(bus_wdata), 32'(e.data));
          end
          last_wr   = bus_wr;
          last_addr = bus_addr;
          last_wd   = bus_wdata;
        end
        prev_strobe = bus_rd | bus_wr;
        if (tx_start) begin
          chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
          tx_log.push_back(tx_data);
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx_start: got tx_data=%0h, expected no transmit (t=%0t)", tx_data, $time);
          end else begin
            t = exp_tx.pop_front();
            chk("tx_data", 32'(tx_data), 32'(t));
          end
        end
        if (frame_err) begin
          chk("frame_err_one_cycle", 32'(prev_err), 32'd0);
          seen_err++;
        end
        prev_err = frame_err;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_reset_outs();
    chk("rst_bus_cs", 32'(bus_cs), 32'd0);
    chk("rst_bus_rd", 32'(bus_rd), 32'd0);
    chk("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
  endtask

  task automatic wait_done();
    int k;
    bit ok;
    k  = 0;
    ok = 1'b0;
    while (k < 500 && !ok) begin
      @(negedge clk);
      ok = (exp_bus.size() == 0) && (exp_tx.size() == 0) && !tx_busy && !tx_start;
      k++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL transaction_timeout: %0d bus ops and %0d tx bytes outstanding, expected none",
               exp_bus.size(), exp_tx.size());
      exp_bus.delete();
      exp_tx.delete();
    end
    repeat (3) @(negedge clk);
    chk("frame_err_count", 32'(seen_err), 32'(exp_err));
    chk("bus_addr_hold", 32'(bus_addr), 32'(mdl_addr));
    chk("bus_wdata_hold", 32'(bus_wdata), 32'(mdl_wd));
  endtask

  task automatic expect_read(input logic [3:0] a);
    bop_t e;
    e.wr = 1'b0;
    e.addr = a;
    e.data = 16'h0000;
    exp_bus.push_back(e);
    exp_tx.push_back(ref_mem[a][15:8]);
    exp_tx.push_back(ref_mem[a][7:0]);
    mdl_addr = a;
  endtask

  // Frame-level model: decode the command byte from the protocol rules and queue the outcome.
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] wd, input int gap);
    bop_t e;
    if (cmd[6:4] != 3'b101) begin
      exp_err++;
      send_byte(cmd);
    end else if (cmd[7]) begin
      e.wr   = 1'b1;
      e.addr = cmd[3:0];
      e.data = wd;
      exp_bus.push_back(e);
      exp_tx.push_back(ACK);
      ref_mem[cmd[3:0]] = wd;
      mdl_addr = cmd[3:0];
      mdl_wd   = wd;
      send_byte(cmd);
      idle(gap);
      send_byte(wd[15:8]);
      idle(gap);
      send_byte(wd[7:0]);
    end else begin
      expect_read(cmd[3:0]);
      send_byte(cmd);
    end
    wait_done();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] c;
    int         base;
    int         k;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    #1 rst = 1'b1;

    // Write D3 00 23
    tx_log.delete();
    run_frame(8'hD3, 16'h0023, 2);
    chk("wr_lit_is_write", 32'(last_wr), 32'd1);
    chk("wr_lit_addr", 32'(last_addr), 32'h3);
    chk("wr_lit_wdata", 32'(last_wd), 32'h0023);
    chk("wr_lit_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) chk("wr_lit_ack", 32'(tx_log[0]), 32'h06);

    // Read 55 returning BEEF
    tx_log.delete();
    run_frame(8'h55, 16'h0000, 0);
    chk("rd_lit_is_read", 32'(last_wr), 32'd0);
    chk("rd_lit_addr", 32'(last_addr), 32'h5);
    chk("rd_lit_tx_count", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() > 1) begin
      chk("rd_lit_hi", 32'(tx_log[0]), 32'hBE);
      chk("rd_lit_lo", 32'(tx_log[1]), 32'hEF);
    end

    // Bad sync
    base = seen_err;
    tx_log.delete();
    run_frame(8'hC3, 16'h0000, 0);
    chk("bad_sync_err_lit", 32'(seen_err - base), 32'd1);
    chk("bad_sync_no_tx", 32'(tx_log.size()), 32'd0);

    // Inter-byte timeout after two bytes, then a normal frame
    base = seen_err;
    exp_err++;
    mdl_addr = 4'h1;
    mdl_wd[15:8] = 8'h12;
    send_byte(8'hD1);
    idle(2);
    send_byte(8'h12);
    idle(150);
    wait_done();
    chk("timeout_err_lit", 32'(seen_err - base), 32'd1);
    run_frame(8'hD7, 16'hA5C3, 1);
    chk("after_timeout_wdata_lit", 32'(last_wd), 32'hA5C3);

    // Overrun during the first response byte of a read
    tx_log.delete();
    expect_read(4'h5);
    send_byte(8'h55);
    k = 0;
    while (k < 50 && !tx_start) begin @(negedge clk); k++; end
    k = 0;
    while (k < 20 && !tx_busy) begin @(negedge clk); k++; end
    chk("overrun_in_txw0", 32'(tx_busy), 32'd1);
    exp_err++;
    send_byte(8'hD4);
    wait_done();
    chk("overrun_tx_count", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() > 1) begin
      chk("overrun_lit_hi", 32'(tx_log[0]), 32'hBE);
      chk("overrun_lit_lo", 32'(tx_log[1]), 32'hEF);
    end

    // Reset while waiting for the low data byte
    send_byte(8'hD2);
    idle(1);
    send_byte(8'h11);
    idle(2);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_bus.delete();
    exp_tx.delete();
    mdl_addr = 4'h0;
    mdl_wd   = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      check_reset_outs();
    end
    @(posedge clk);
    #1 rst = 1'b1;
    idle(30);
    wait_done();
    run_frame(8'h22, 16'h0000, 0);

    // Reset in the middle of a read response
    expect_read(4'h7);
    send_byte(8'h57);
    k = 0;
    while (k < 50 && !tx_start) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_bus.delete();
    exp_tx.delete();
    mdl_addr = 4'h0;
    mdl_wd   = 16'h0000;
    @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    #1 rst = 1'b1;
    idle(30);
    wait_done();

    // Randomised frames, mostly valid sync
    for (int i = 0; i < 60; i++) begin
      c = 8'($urandom);
      if ($urandom_range(0, 9) < 8) c[6:4] = 3'b101;
      run_frame(c, 16'($urandom), $urandom_range(1, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz).
REQ-002 Parameter RD_LAT, default 1, cycles from bus_rd strobe to valid bus_rdata (range 1..3).
REQ-003 Parameter ACK_BYTE, default 8'h06, byte returned after a completed write.
REQ-004 clk  in  1  single system clock, rising-edge.
REQ-005 rst  in  1  reset; asynchronous assert, active-low.
REQ-006 rx_data  in  8  byte from UART receiver, valid when rx_valid=1.
REQ-007 rx_valid  in  1  one-cycle strobe per received byte.
REQ-008 tx_data  out  8  byte to UART transmitter, stable while tx_start=1.
REQ-009 tx_start  out  1  one-cycle transmit request.
REQ-010 tx_busy  in  1  transmitter busy; high from cycle after tx_start until byte sent.
REQ-011 bus_cs  out  1  chip select to motion-control peripheral.
REQ-012 bus_addr  out  4  register address.
REQ-013 bus_rd / bus_wr  out  1 each  read / write strobes.
REQ-014 bus_wdata  out  16  write data (drives peripheral d_in).
REQ-015 bus_rdata  in  16  read data (from peripheral d_out).
REQ-016 frame_err  out  1  one-cycle pulse on any protocol error.

Function
REQ-017 Command byte: bit7 = 1 write / 0 read; bits6:4 SHALL equal 3'b101 (sync); bits3:0 = address.
REQ-018 Write frame = command, data-high, data-low; read frame = command only.
REQ-019 FSM states: IDLE, GET_HI, GET_LO, BUS_WR, BUS_RD, RD_WAIT, TX0, TXW0, TX1, TXW1.
REQ-020 IDLE: rx_valid with valid sync latches address; bit7=1 -> GET_HI, bit7=0 -> BUS_RD.
REQ-021 IDLE: rx_valid with bad sync -> byte discarded, frame_err pulse, stay IDLE.
REQ-022 GET_HI/GET_LO: each rx_valid latches wdata[15:8] / wdata[7:0]; GET_LO -> BUS_WR.
REQ-023 BUS_WR: bus_cs=bus_wr=1 for exactly one cycle with bus_addr/bus_wdata stable; then TX0 with tx_data=ACK_BYTE; then IDLE after TXW0.
REQ-024 BUS_RD: bus_cs=bus_rd=1 for exactly one cycle; RD_WAIT counts RD_LAT-1 further cycles, then samples bus_rdata into a 16-bit holding register.
REQ-025 Read response: TX0 sends rdata[15:8], TX1 sends rdata[7:0], high byte first.
REQ-026 TXn: tx_start pulses only in a cycle where tx_busy=0; TXWn waits one cycle then until tx_busy=0.
REQ-027 Timeout counter resets on each accepted byte; reaching TIMEOUT_CYC in GET_HI or GET_LO -> frame_err pulse, partial frame dropped, IDLE, no bus access.
REQ-028 rx_valid in any state other than IDLE/GET_HI/GET_LO -> byte dropped, frame_err pulse, current transaction completes unaffected.
REQ-029 bus_cs, bus_rd, bus_wr SHALL never be high outside BUS_WR/BUS_RD; bus_rd and bus_wr never simultaneously high.
REQ-030 bus_addr, bus_wdata hold last latched values between transactions.

Reset
REQ-031 On rst=0: state IDLE; bus_cs, bus_rd, bus_wr, tx_start, frame_err = 0; bus_addr=4'h0; bus_wdata=16'h0000; tx_data=8'h00; timeout and latency counters cleared.
REQ-032 Reset asserted mid-frame or mid-transmit aborts immediately; no bus strobe or tx_start issued after release until a new complete frame arrives.

Structure
REQ-033 Shared package bridge_pkg holds: state enum, SYNC_PATTERN=3'b101, command bit positions, default ACK_BYTE.
REQ-034 One sub-module, bridge_timeout: loadable down-counter (clear, enable, expired) parameterised by TIMEOUT_CYC.

Verification
REQ-035 Write: bytes 8'hD3, 8'h00, 8'h23 -> one-cycle bus_cs=bus_wr=1, bus_addr=4'h3, bus_wdata=16'h0023; then tx_start with tx_data=8'h06.
REQ-036 Read, RD_LAT=1: byte 8'h55, peripheral returns 16'hBEEF -> one bus_rd pulse at addr 4'h5; tx bytes 8'hBE then 8'hEF, second tx_start only after tx_busy falls.
REQ-037 Bad sync: byte 8'hC3 -> frame_err pulse, no bus strobe, no tx_start.
REQ-038 Timeout (TIMEOUT_CYC=100): 8'hD1, 8'h12, then 150 idle cycles -> frame_err pulse, no bus_wr; subsequent valid frame executes normally.
REQ-039 Overrun: byte injected during TXW0 of a read -> frame_err pulse, both response bytes still sent correctly.
REQ-040 Reset in GET_LO: rst low 3 cycles after 8'hD2, 8'h11 -> all outputs at reset values, no bus_wr after release.
